fetch_prefetch_unit: RTL and testbench

- Parametrised instruction fetch stage with a DEPTH-entry prefetch buffer, decoupling instruction-memory latency (busywait) from decode stalls.
- Sits between instruction memory and the IF/ID pipeline register.
- Replaces the PC register, PC+4 adder and PC select muxes of the current IF stage.
- Accepts a single redirect (branch/jump/flush) input and a decode hold (load-use stall) input.

---
 rtl/fetch_prefetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction fetch stage with a DEPTH-entry circular prefetch buffer.
// It owns the fetch PC and the PC+4 increment. It isolates instruction-memory
// wait states (IMEM_BUSYWAIT) from decode stalls (ID_HOLD).
// A redirect flushes the buffer and restarts fetch at a word-aligned target.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/redirect counters.

module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  output logic [XLEN-1:0]        IMEM_ADDR,
  output logic                   IMEM_READ,
  input  logic [31:0]            IMEM_INSTR,
  input  logic                   IMEM_BUSYWAIT,
  input  logic                   REDIRECT,
  input  logic [XLEN-1:0]        REDIRECT_PC,
  input  logic                   ID_HOLD,
  output logic                   ID_VALID,
  output logic [XLEN-1:0]        ID_PC,
  output logic [31:0]            ID_INSTRUCTION,
  output logic [$clog2(DEPTH):0] BUF_COUNT
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            FETCH_STALL_CYCLES,
  output logic [31:0]            FETCH_REDIRECTS
`endif
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP_INSTR  = 32'h00000013;

  logic [XLEN-1:0]  fetch_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [XLEN-1:0]  pc_buf    [DEPTH];
  logic [31:0]      instr_buf [DEPTH];

  logic             push;
  logic             pop;
  logic             buf_empty;
  logic             buf_full;
  logic [XLEN-1:0]  redirect_target;

  // Request generation and push/pop qualification; redirect suppresses both
  always_comb begin
    buf_empty       = (count == '0);
    buf_full        = (count == FULL_COUNT);
    redirect_target = REDIRECT_PC & ~XLEN'(3);
    IMEM_ADDR       = fetch_pc;
    IMEM_READ       = !RESET && !REDIRECT && !buf_full;
    push            = IMEM_READ && !IMEM_BUSYWAIT;
    pop             = !buf_empty && !ID_HOLD && !REDIRECT;
  end

  // Present the buffer head to decode, or a NOP bubble when empty
  always_comb begin
    ID_VALID       = !buf_empty;
    ID_PC          = '0;
    ID_INSTRUCTION = NOP_INSTR;
    BUF_COUNT      = count;
    if (!buf_empty) begin
      ID_PC          = pc_buf[rd_ptr];
      ID_INSTRUCTION = instr_buf[rd_ptr];
    end
  end

  // Fetch PC, pointers and occupancy; redirect overrides any push or pop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (REDIRECT) begin
      fetch_pc <= redirect_target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage is only read through the count-qualified head, so it needs no reset
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_buf[wr_ptr]    <= fetch_pc;
      instr_buf[wr_ptr] <= IMEM_INSTR;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters for memory wait cycles and redirect cycles
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FETCH_STALL_CYCLES <= '0;
      FETCH_REDIRECTS    <= '0;
    end else begin
      if (IMEM_READ && IMEM_BUSYWAIT && (FETCH_STALL_CYCLES != '1)) begin
        FETCH_STALL_CYCLES <= FETCH_STALL_CYCLES + 32'd1;
      end
      if (REDIRECT && (FETCH_REDIRECTS != '1)) begin
        FETCH_REDIRECTS <= FETCH_REDIRECTS + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit
// Drives directed and random fetch traffic into fetch_prefetch_unit.
// Compares every cycle against a queue-based model of the prefetch buffer.
// Honours FETCH_PERF_CNT_EN when defined.

module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imemAddr;
  logic        imemRead;
  logic [31:0] imemInstr;
  logic        imemBusywait;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        idHold;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idInstruction;
  logic [2:0]  bufCount;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchStallCycles;
  logic [31:0] fetchRedirects;
  logic [31:0] modelStalls;
  logic [31:0] modelRedirects;
`endif

  entry_t      modelQ[$];
  logic [31:0] modelPc;
  int          checkCount = 0;
  int          passCount  = 0;

  fetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK            (clock),
    .RESET          (reset),
    .IMEM_ADDR      (imemAddr),
    .IMEM_READ      (imemRead),
    .IMEM_INSTR     (imemInstr),
    .IMEM_BUSYWAIT  (imemBusywait),
    .REDIRECT       (redirect),
    .REDIRECT_PC    (redirectPc),
    .ID_HOLD        (idHold),
    .ID_VALID       (idValid),
    .ID_PC          (idPc),
    .ID_INSTRUCTION (idInstruction),
    .BUF_COUNT      (bufCount)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FETCH_STALL_CYCLES (fetchStallCycles),
    .FETCH_REDIRECTS    (fetchRedirects)
`endif
  );

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  // Distinct, address-dependent word for every instruction address
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  // Instruction memory answers whatever address the DUT presents
  always_comb imemInstr = memWord(imemAddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelPc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    modelStalls    = 32'h0;
    modelRedirects = 32'h0;
`endif
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_read"},  {31'd0, imemRead}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, idValid},  32'd0);
    checkOutput({tag, "_pc"},    idPc,              32'd0);
    checkOutput({tag, "_instr"}, idInstruction,     32'h00000013);
    checkOutput({tag, "_count"}, {29'd0, bufCount}, 32'd0);
    checkOutput({tag, "_addr"},  imemAddr,          32'd0);
  endtask

  // Called at a falling edge: drive inputs, check against the model, then advance the model over the rising edge
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic hold, input logic busy);
    logic   expRead;
    logic   doPop;
    entry_t head;
    entry_t e;
    redirect     = redir;
    redirectPc   = rpc;
    idHold       = hold;
    imemBusywait = busy;
    #1;
    expRead = !redir && (modelQ.size() < DEPTH);
    checkOutput("imem_read",  {31'd0, imemRead}, {31'd0, expRead});
    checkOutput("imem_addr",  imemAddr, modelPc);
    checkOutput("id_valid",   {31'd0, idValid}, (modelQ.size() != 0) ? 32'd1 : 32'd0);
    checkOutput("buf_count",  {29'd0, bufCount}, 32'(modelQ.size()));
    if (modelQ.size() != 0) begin
      head = modelQ[0];
      checkOutput("id_pc",    idPc, head.pc);
      checkOutput("id_instr", idInstruction, head.instr);
    end else begin
      checkOutput("id_pc",    idPc, 32'h0);
      checkOutput("id_instr", idInstruction, 32'h00000013);
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("stall_cnt",    fetchStallCycles, modelStalls);
    checkOutput("redirect_cnt", fetchRedirects, modelRedirects);
    if (expRead && busy && modelStalls != 32'hFFFFFFFF) modelStalls++;
    if (redir && modelRedirects != 32'hFFFFFFFF) modelRedirects++;
`endif
    if (redir) begin
      modelQ.delete();
      modelPc = {rpc[31:2], 2'b00};
    end else begin
      doPop = (modelQ.size() != 0) && !hold;
      if (doPop) void'(modelQ.pop_front());
      if (expRead && !busy) begin
        e.pc    = modelPc;
        e.instr = memWord(modelPc);
        modelQ.push_back(e);
        modelPc = modelPc + 32'd4;
      end
    end
    @(negedge clock);
  endtask

  // Asynchronous reset pulse between clock edges, held across one rising edge
  task automatic pulseReset();
    #2 reset = 1'b1;
    #1 checkResetValues("async_rst");
    @(negedge clock);
    #1 checkResetValues("held_rst");
    reset        = 1'b0;
    redirect     = 1'b0;
    idHold       = 1'b0;
    imemBusywait = 1'b0;
    modelReset();
  endtask

  // Directed scenarios first, then randomized traffic with a mid-run reset
  initial begin
    reset        = 1'b1;
    redirect     = 1'b0;
    redirectPc   = 32'h0;
    idHold       = 1'b0;
    imemBusywait = 1'b0;
    modelReset();
    repeat (2) @(negedge clock);
    #1 checkResetValues("reset");
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] zero-wait streaming");
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] decode hold fills buffer");
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (6)  applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] busywait at 0x10");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    #1 checkOutput("stall_three", fetchStallCycles, 32'd3);
`endif

    $display("[TB] redirect with buffered entries and pending busywait");
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h103, 1'b1, 1'b1);
    #1;
    checkOutput("redir_count", {29'd0, bufCount}, 32'd0);
    checkOutput("redir_addr",  imemAddr, 32'h100);
    checkOutput("redir_valid", {31'd0, idValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1 checkOutput("redir_head", idPc, 32'h100);

    $display("[TB] simultaneous push and pop at count 2");
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1 checkOutput("pushpop_count", {29'd0, bufCount}, 32'd2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(15) == 0, $urandom, $urandom_range(2) == 0, $urandom_range(3) == 0);
    end
    pulseReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(15) == 0, $urandom, $urandom_range(2) == 0, $urandom_range(3) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
